serial_adder: RTL

- Bit-serial ripple adder that adds two WIDTH-bit operands LSB-first through a single full-adder cell and a carry flip-flop, taking one bit per clock.
- Sits directly downstream of the half-adder cell. Two half-adder instances form the full-adder bit slice that this block sequences over time.
- Uses a valid/ready handshake on input and output so a controller or bench can stream operand pairs.

---
 rtl/adder_pkg.sv | 13 +
 rtl/serial_adder_full_adder.sv | 26 ++
 rtl/serial_adder.sv | 113 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared state encoding and default width for the bit-serial adder.
// SERIAL_ADDER_SUB_EN (see serial_adder.sv) adds a subtract mode.
package adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder slice built from two half-adder cells.
// The serial adder clocks this slice once per operand bit.
module half_adder (
   input  logic a_i,
   input  logic b_i,
   output logic sum_o,
   output logic cout_o
);
   assign sum_o  = a_i ^ b_i;
   assign cout_o = a_i & b_i;
endmodule

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);
   logic s0, c0, c1;

   half_adder u_ha0 (.a_i(a_i), .b_i(b_i),   .sum_o(s0),    .cout_o(c0));
   half_adder u_ha1 (.a_i(s0),  .b_i(cin_i), .sum_o(sum_o), .cout_o(c1));

   assign cout_o = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice plus a carry flop, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting a - b.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       state_o
);
   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // ready never depends on valid, and sum/cout are meaningful only while out_valid=1.

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;
   logic             fa_s, fa_c;

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: a + ~b + 1; final carry=1 means no borrow.
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   full_adder u_fa (
      .a_i   (a_sh_q[0]),
      .b_i   (b_sh_q[0]),
      .cin_i (carry_q),
      .sum_o (fa_s),
      .cout_o(fa_c)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sh_d   = a;
               b_sh_d   = b_load;
               carry_d  = carry_load;
               sum_sh_d = '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d  = fa_c;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign sum       = sum_sh_q;
   assign cout      = carry_q;
   assign state_o   = state_q;

endmodule
